// File: rtl/cpu16_pkg.sv
// Shared types and constants for the 16-bit CPU front end.
package cpu16_pkg;

   localparam int WORD_W = 16;
   localparam logic [WORD_W-1:0] HALT_INSTR = 16'hFFFF;

   typedef enum logic [1:0] {
      RUN,
      HALT_PEND,
      HALTED
   } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO between instruction memory responses and the decode handshake.
// The caller guarantees push never happens when full; flush empties it in one cycle.
module fetch_fifo #(
   parameter int DEPTH  = 4,
   parameter int DATA_W = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    push,
   input  logic [DATA_W-1:0]       push_data,
   input  logic                    pop,
   input  logic                    flush,
   output logic [DATA_W-1:0]       head,
   output logic [$clog2(DEPTH):0]  count,
   output logic                    empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;

   // NOTE: storage is deliberately not reset; only pointers and count need defined values.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= push_data;
   end

   // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + CNT_W'(push) - CNT_W'(pop);
      end
   end

   assign head  = mem[rd_ptr];
   assign empty = (count == '0);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues pipelined imem reads, handles redirects and halt.
// Optional build macro FETCH_STATS_EN adds stat_fetched / stat_flushed counters.
module fetch_unit
   import cpu16_pkg::*;
#(
   parameter int                DEPTH    = 4,
   parameter int                ADDR_W   = 16,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_valid,
   input  logic [WORD_W-1:0] imem_rdata,
   input  logic              redirect,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              instr_valid,
   input  logic              instr_ready,
   output logic [WORD_W-1:0] instr,
   output logic [ADDR_W-1:0] instr_pc,
   output logic              halted
`ifdef FETCH_STATS_EN
   ,
   output logic [15:0]       stat_fetched,
   output logic [15:0]       stat_flushed
`endif
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   fetch_state_t      state;
   fetch_state_t      state_next;
   logic [ADDR_W-1:0] pc;
   logic [CNT_W-1:0]  outstanding;
   logic [CNT_W-1:0]  discard;
   logic [CNT_W-1:0]  fifo_count;
   logic              fifo_empty;
   logic [WORD_W+ADDR_W-1:0] fifo_head;

   // Addresses of in-flight requests, consumed in order as responses return.
   logic [ADDR_W-1:0] pend_addr [DEPTH];
   logic [PTR_W-1:0]  pend_wr;
   logic [PTR_W-1:0]  pend_rd;

   logic redirect_eff;
   logic resp;
   logic drop;
   logic push;
   logic issue;
   logic xfer;

   assign redirect_eff = redirect && (state != HALTED);
   assign resp         = imem_valid && (outstanding != '0);
   assign drop         = resp && (redirect_eff || (discard != '0));
   assign push         = resp && !drop;
   assign issue        = !rst && (state == RUN) && !redirect_eff &&
                         (({1'b0, fifo_count} + {1'b0, outstanding}) < (CNT_W+1)'(DEPTH));
   assign xfer         = instr_valid && instr_ready;

   assign imem_req    = issue;
   assign imem_addr   = pc;
   assign instr_valid = !fifo_empty && (state != HALTED);
   assign instr       = fifo_head[WORD_W+ADDR_W-1 -: WORD_W];
   assign instr_pc    = fifo_head[ADDR_W-1:0];
   assign halted      = (state == HALTED);

   fetch_fifo #(
      .DEPTH  (DEPTH),
      .DATA_W (WORD_W + ADDR_W)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data ({imem_rdata, pend_addr[pend_rd]}),
      .pop       (xfer),
      .flush     (redirect_eff),
      .head      (fifo_head),
      .count     (fifo_count),
      .empty     (fifo_empty)
   );

   // NOTE: the default assignment first keeps this block free of inferred latches.
   always_comb begin
      state_next = state;
      if (redirect_eff) begin
         state_next = RUN;
      end else begin
         case (state)
            RUN:       if (push && (imem_rdata == HALT_INSTR)) state_next = HALT_PEND;
            HALT_PEND: if (xfer && (instr == HALT_INSTR))      state_next = HALTED;
            default:   state_next = state;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= RUN;
         pc          <= RESET_PC;
         outstanding <= '0;
         discard     <= '0;
         pend_wr     <= '0;
         pend_rd     <= '0;
      end else begin
         state       <= state_next;
         outstanding <= outstanding + CNT_W'(issue) - CNT_W'(resp);
         if (redirect_eff)  pc <= redirect_pc;
         else if (issue)    pc <= pc + 1'b1;
         // Everything still in flight after this cycle belongs to the abandoned stream.
         if (redirect_eff)                  discard <= outstanding - CNT_W'(resp);
         else if (resp && (discard != '0))  discard <= discard - 1'b1;
         if (issue) pend_wr <= pend_wr + 1'b1;
         if (resp)  pend_rd <= pend_rd + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (issue) pend_addr[pend_wr] <= pc;
   end

`ifdef FETCH_STATS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         stat_fetched <= '0;
         stat_flushed <= '0;
      end else begin
         if (push) stat_fetched <= stat_fetched + 16'd1;
         if (redirect_eff) stat_flushed <= stat_flushed + 16'(fifo_count) + 16'(resp);
         else if (drop)    stat_flushed <= stat_flushed + 16'd1;
      end
   end
`endif

   response_without_request: assert property (
      @(posedge clk) disable iff (rst) imem_valid |-> (outstanding != '0));

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: randomized imem latency, backpressure, redirects, halt and reset.
module tb_fetch_unit;
   import cpu16_pkg::*;

   localparam int                DEPTH    = 4;
   localparam int                ADDR_W   = 16;
   localparam logic [ADDR_W-1:0] RESET_PC = '0;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              imem_req;
   logic [ADDR_W-1:0] imem_addr;
   logic              imem_valid = 1'b0;
   logic [15:0]       imem_rdata = '0;
   logic              redirect = 1'b0;
   logic [ADDR_W-1:0] redirect_pc = '0;
   logic              instr_valid;
   logic              instr_ready = 1'b0;
   logic [15:0]       instr;
   logic [ADDR_W-1:0] instr_pc;
   logic              halted;
`ifdef FETCH_STATS_EN
   logic [15:0]       stat_fetched;
   logic [15:0]       stat_flushed;
`endif

   always #5 clk = ~clk;

   fetch_unit #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) dut (
      .clk         (clk),
      .rst         (rst),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_valid  (imem_valid),
      .imem_rdata  (imem_rdata),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .instr       (instr),
      .instr_pc    (instr_pc),
      .halted      (halted)
`ifdef FETCH_STATS_EN
      ,
      .stat_fetched(stat_fetched),
      .stat_flushed(stat_flushed)
`endif
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
   endtask

   // Program image: every word has bit 15 clear except an optional halt word.
   logic              halt_en = 1'b0;
   logic [ADDR_W-1:0] halt_addr = '0;

   function automatic logic [15:0] word_at(input logic [ADDR_W-1:0] a);
      if (halt_en && (a == halt_addr)) return HALT_INSTR;
      return {1'b0, a[14:0] ^ 15'h2A5B};
   endfunction

   // Instruction memory model: in-order responses after a random latency.
   typedef struct { logic [ADDR_W-1:0] addr; int due; } req_t;
   req_t rq[$];
   int   cyc = 0;
   int   last_due = 0;
   int   new_due;
   int   lat_min = 1;
   int   lat_max = 1;
   int   req_cnt = 0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (!rst && imem_req) begin
         new_due = cyc + int'($urandom_range(lat_max, lat_min));
         if (new_due <= last_due) new_due = last_due + 1;
         last_due = new_due;
         rq.push_back('{imem_addr, new_due});
         req_cnt++;
      end
   end

   task automatic step();
      req_t r;
      @(posedge clk);
      #1;
      imem_valid = 1'b0;
      imem_rdata = '0;
      if (rq.size() > 0) begin
         if (rq[0].due <= cyc) begin
            r = rq.pop_front();
            imem_valid = 1'b1;
            imem_rdata = word_at(r.addr);
         end
      end
   endtask

   // Reference stream: sequential fetch from a start address up to and including a halt word.
   typedef struct { logic [ADDR_W-1:0] pc; logic [15:0] instr; } exp_t;
   exp_t eq[$];

   task automatic load_expected(input logic [ADDR_W-1:0] start);
      logic [ADDR_W-1:0] a;
      a = start;
      eq.delete();
      for (int i = 0; i < 400; i++) begin
         eq.push_back('{a, word_at(a)});
         if (word_at(a) == HALT_INSTR) break;
         a = a + 1'b1;
      end
   endtask

   // Monitor: pops the scoreboard on every downstream transfer.
   logic              exp_halted = 1'b0;
   int                xfer_cnt = 0;
   int                first_xfer_cyc = 0;
   logic [ADDR_W-1:0] first_pc = '0;
   exp_t              mon_e;

   always @(negedge clk) begin
      if (!rst) begin
         check("halted", 32'(halted), 32'(exp_halted));
         if (exp_halted) begin
            check("halted_no_valid", 32'(instr_valid), 32'd0);
            check("halted_no_req", 32'(imem_req), 32'd0);
         end
         if (instr_valid && instr_ready) begin
            if (xfer_cnt == 0) begin
               first_xfer_cyc = cyc;
               first_pc       = instr_pc;
            end
            xfer_cnt++;
            if (eq.size() == 0) begin
               check("unexpected_xfer", 32'(instr_valid), 32'd0);
            end else begin
               mon_e = eq.pop_front();
               check("xfer_pc", 32'(instr_pc), 32'(mon_e.pc));
               check("xfer_instr", 32'(instr), 32'(mon_e.instr));
               if (mon_e.instr == HALT_INSTR) exp_halted = 1'b1;
            end
         end
      end
   end

   int rel_cyc = 0;

   task automatic do_reset(input int cycles);
      rst         = 1'b1;
      instr_ready = 1'b0;
      redirect    = 1'b0;
      rq.delete();
      eq.delete();
      last_due    = 0;
      exp_halted  = 1'b0;
      for (int i = 0; i < cycles; i++) begin
         step();
         #2;
         check("rst_req", 32'(imem_req), 32'd0);
         check("rst_valid", 32'(instr_valid), 32'd0);
         check("rst_halted", 32'(halted), 32'd0);
      end
      rst      = 1'b0;
      rel_cyc  = cyc;
      xfer_cnt = 0;
      req_cnt  = 0;
      load_expected(RESET_PC);
      #1;
      check("post_rst_req", 32'(imem_req), 32'd1);
      check("post_rst_addr", 32'(imem_addr), 32'(RESET_PC));
      check("post_rst_valid", 32'(instr_valid), 32'd0);
      check("post_rst_halted", 32'(halted), 32'd0);
`ifdef FETCH_STATS_EN
      check("post_rst_fetched", 32'(stat_fetched), 32'd0);
      check("post_rst_flushed", 32'(stat_flushed), 32'd0);
`endif
   endtask

   task automatic redirect_cycle(input logic [ADDR_W-1:0] target);
      redirect    = 1'b1;
      redirect_pc = target;
      instr_ready = 1'b0;
      #2;
      check("redirect_blocks_issue", 32'(imem_req), 32'd0);
      step();
      redirect = 1'b0;
      load_expected(target);
      xfer_cnt = 0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   logic rnd_redirect;
   logic ign;

   initial begin
      // Streaming with a 1-cycle memory: first word two cycles after reset, then one per cycle.
      lat_min = 1; lat_max = 1;
      do_reset(2);
      instr_ready = 1'b1;
      repeat (22) step();
      check("fill_latency", 32'(first_xfer_cyc - rel_cyc), 32'd2);
      check("stream_count", 32'(xfer_cnt), 32'd20);

      // Backpressure: the issue cap stops at DEPTH requests.
      do_reset(1);
      repeat (10) step();
      #2;
      check("stall_req_count", 32'(req_cnt), 32'(DEPTH));
      check("stall_req_low", 32'(imem_req), 32'd0);
      instr_ready = 1'b1;
      repeat (20) step();
      check("stall_first_pc", 32'(first_pc), 32'(RESET_PC));
      check("stall_progress", 32'(xfer_cnt >= 10), 32'd1);

      // Redirect with three requests in flight on a 3-cycle memory.
      lat_min = 3; lat_max = 3;
      do_reset(1);
      instr_ready = 1'b1;
      repeat (3) step();
      redirect_cycle(16'h0040);
      instr_ready = 1'b1;
      #2;
      check("redir_req", 32'(imem_req), 32'd1);
      check("redir_addr", 32'(imem_addr), 32'h0040);
      check("redir_flushed", 32'(instr_valid), 32'd0);
      repeat (20) step();
      check("redir_first_pc", 32'(first_pc), 32'h0040);

      // Redirect coinciding with a response while the FIFO holds three words.
      lat_min = 1; lat_max = 1;
      do_reset(1);
      repeat (4) step();
      redirect_cycle(16'h1234);
      #2;
      check("redir_full_empty", 32'(instr_valid), 32'd0);
      check("redir_full_addr", 32'(imem_addr), 32'h1234);
`ifdef FETCH_STATS_EN
      check("redir_full_fetched", 32'(stat_fetched), 32'd3);
      check("redir_full_flushed", 32'(stat_flushed), 32'd4);
`endif
      instr_ready = 1'b1;
      repeat (15) step();
      check("redir_full_first_pc", 32'(first_pc), 32'h1234);

      // Halt word at address 5, then a redirect that must be ignored.
      halt_en = 1'b1; halt_addr = 16'd5;
      do_reset(1);
      instr_ready = 1'b1;
      repeat (30) step();
      #2;
      check("halt_state", 32'(halted), 32'd1);
      check("halt_count", 32'(xfer_cnt), 32'd6);
      redirect = 1'b1; redirect_pc = 16'h0080;
      step();
      redirect = 1'b0;
      repeat (5) step();
      #2;
      check("halt_sticky", 32'(halted), 32'd1);
      check("halt_no_req_after_redirect", 32'(imem_req), 32'd0);
      check("halt_count_after_redirect", 32'(xfer_cnt), 32'd6);
      halt_en = 1'b0;

      // Reset in the middle of a 2-cycle-latency stream.
      lat_min = 2; lat_max = 2;
      do_reset(1);
      instr_ready = 1'b1;
      repeat (6) step();
      do_reset(1);
      instr_ready = 1'b1;
      repeat (10) step();
      check("midrst_first_pc", 32'(first_pc), 32'(RESET_PC));

      // Randomized episodes.
      for (int ep = 0; ep < 6; ep++) begin
         halt_en   = ep[0];
         halt_addr = 16'($urandom_range(60, 3));
         lat_min   = 1;
         lat_max   = int'($urandom_range(4, 1));
         do_reset(1 + (ep % 2));
         for (int c = 0; c < 300; c++) begin
            if ((c == 150) && (ep >= 4)) do_reset(1);
            rnd_redirect = ($urandom_range(24, 0) == 0);
            ign = exp_halted;
            redirect = rnd_redirect;
            if (rnd_redirect) begin
               case ($urandom_range(2, 0))
                  0:       redirect_pc = halt_addr - 16'($urandom_range(8, 0));
                  1:       redirect_pc = 16'hFFFC + 16'($urandom_range(3, 0));
                  default: redirect_pc = 16'($urandom);
               endcase
            end
            instr_ready = rnd_redirect ? 1'b0 : ($urandom_range(9, 0) < 7);
            step();
            if (rnd_redirect && !ign) load_expected(redirect_pc);
            redirect = 1'b0;
         end
         check("episode_progress", 32'(xfer_cnt > 0), 32'd1);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
